// File: rtl/brick_ram_arbiter_pkg.sv
// Shared brick-game sizing constants for the brick RAM arbiter and its users.
package brick_ram_arbiter_pkg;
  localparam int BRICK_ADDR_W = 10;
  localparam int BRICK_HP_W   = 2;
  localparam int BRICK_TOT_W  = 10;
  localparam int BRICKNUM     = 1 << BRICK_ADDR_W;
endpackage

// File: rtl/brick_ram_arbiter_if.sv
// Loader / collision / brick-RAM / level-health signal bundle of the arbiter.
interface brick_ram_arbiter_if
  import brick_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = BRICK_ADDR_W,
  parameter int HP_W   = BRICK_HP_W,
  parameter int TOT_W  = BRICK_TOT_W
) ();
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [HP_W-1:0]   ld_health;
  logic              ld_grant;
  logic              hit_req;
  logic [ADDR_W-1:0] hit_addr;
  logic              hit_ack;
  logic              hit_valid;
  logic              hit_destroyed;
  logic [ADDR_W-1:0] ram_addr;
  logic [HP_W-1:0]   ram_wdata;
  logic              ram_we;
  logic [HP_W-1:0]   ram_rdata;
  logic              lvl_load;
  logic [TOT_W-1:0]  lvl_total;
  logic [TOT_W-1:0]  hp_left;
  logic              level_clear;
  logic              busy;

  modport slave (
    input  ld_req, ld_addr, ld_health, hit_req, hit_addr, ram_rdata, lvl_load, lvl_total,
    output ld_grant, hit_ack, hit_valid, hit_destroyed, ram_addr, ram_wdata, ram_we,
           hp_left, level_clear, busy
  );

  modport master (
    output ld_req, ld_addr, ld_health, hit_req, hit_addr, ram_rdata, lvl_load, lvl_total,
    input  ld_grant, hit_ack, hit_valid, hit_destroyed, ram_addr, ram_wdata, ram_we,
           hp_left, level_clear, busy
  );
endinterface

// File: rtl/brick_ram_arbiter_hp_tracker.sv
// Remaining level health: loaded on lvl_load, decremented per damaged brick, floor at 0.
module brick_hp_tracker
  import brick_ram_arbiter_pkg::*;
#(
  parameter int TOT_W = BRICK_TOT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [TOT_W-1:0] total,
  input  logic             dec,
  output logic [TOT_W-1:0] hp_left,
  output logic             level_clear
);
  logic [TOT_W-1:0] hp_q, hp_d;
  logic             loaded_q, loaded_d;

  always_comb begin
    hp_d     = hp_q;
    loaded_d = loaded_q;
    if (load) begin
      hp_d     = total;
      loaded_d = 1'b1;
    end else if (dec && hp_q != '0) begin
      hp_d = hp_q - TOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hp_q     <= '0;
      loaded_q <= 1'b0;
    end else begin
      hp_q     <= hp_d;
      loaded_q <= loaded_d;
    end
  end

  assign hp_left     = hp_q;
  // Held low while reset is applied, not just after the reset edge.
  assign level_clear = resetn & loaded_q & (hp_q == '0);
endmodule

// File: rtl/brick_ram_arbiter.sv
// Arbitrates the single-port brick RAM between the level loader (priority) and
// collision damage read-modify-write, and tracks remaining level health.
module brick_ram_arbiter
  import brick_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = BRICK_ADDR_W,
  parameter int HP_W   = BRICK_HP_W,
  parameter int TOT_W  = BRICK_TOT_W
) (
  input  logic               clk,
  input  logic               resetn,
  brick_ram_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_WR   = 3'd1;
  localparam logic [2:0] S_HIT_RD  = 3'd2;
  localparam logic [2:0] S_HIT_CHK = 3'd3;
  localparam logic [2:0] S_HIT_WR  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HP_W-1:0]   data_q, data_d;

  logic [ADDR_W-1:0] ram_addr_c;
  logic [HP_W-1:0]   ram_wdata_c;
  logic              ram_we_c, ld_grant_c, hit_ack_c, hit_valid_c, hit_destroyed_c, dec_c;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    ram_addr_c      = '0;
    ram_wdata_c     = '0;
    ram_we_c        = 1'b0;
    ld_grant_c      = 1'b0;
    hit_ack_c       = 1'b0;
    hit_valid_c     = 1'b0;
    hit_destroyed_c = 1'b0;
    dec_c           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ld_req) begin
          addr_d  = bus.ld_addr;
          data_d  = bus.ld_health;
          state_d = S_LD_WR;
        end else if (bus.hit_req) begin
          addr_d  = bus.hit_addr;
          data_d  = '0;
          state_d = S_HIT_RD;
        end
      end
      S_LD_WR: begin
        ram_addr_c  = addr_q;
        ram_wdata_c = data_q;
        ram_we_c    = 1'b1;
        ld_grant_c  = 1'b1;
        state_d     = S_IDLE;
      end
      S_HIT_RD: begin
        ram_addr_c = addr_q;
        state_d    = S_HIT_CHK;
      end
      S_HIT_CHK: begin
        ram_addr_c = addr_q;
        if (bus.ram_rdata == '0) begin
          hit_ack_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          data_d  = bus.ram_rdata;
          state_d = S_HIT_WR;
        end
      end
      S_HIT_WR: begin
        ram_addr_c      = addr_q;
        ram_wdata_c     = data_q - HP_W'(1);
        ram_we_c        = 1'b1;
        hit_ack_c       = 1'b1;
        hit_valid_c     = 1'b1;
        hit_destroyed_c = (data_q == HP_W'(1));
        dec_c           = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Reset masks outputs combinationally so a transaction caught mid-flight is never acked.
  assign bus.ram_addr      = resetn ? ram_addr_c : '0;
  assign bus.ram_wdata     = resetn ? ram_wdata_c : '0;
  assign bus.ram_we        = resetn & ram_we_c;
  assign bus.ld_grant      = resetn & ld_grant_c;
  assign bus.hit_ack       = resetn & hit_ack_c;
  assign bus.hit_valid     = resetn & hit_valid_c;
  assign bus.hit_destroyed = resetn & hit_destroyed_c;
  assign bus.busy          = resetn & (state_q != S_IDLE);

  brick_hp_tracker #(.TOT_W(TOT_W)) u_hp (
    .clk         (clk),
    .resetn      (resetn),
    .load        (bus.lvl_load),
    .total       (bus.lvl_total),
    .dec         (dec_c),
    .hp_left     (bus.hp_left),
    .level_clear (bus.level_clear)
  );
endmodule

// File: doc/brick_ram_arbiter.md
BRICK_RAM_ARBITER -- requirements
Module: brick_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 10, brick RAM address width (one word per brick slot).
REQ-002 Parameter HP_W, 2, brick health width (0 = no brick).
REQ-003 Parameter TOT_W, 10, level total-health width.
REQ-004 clk  in  1  system clock; all state updates on posedge clk.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 ld_req  in  1  loader write request; held until ld_grant.
REQ-007 ld_addr  in  ADDR_W  loader brick address.
REQ-008 ld_health  in  HP_W  loader brick health to write.
REQ-009 ld_grant  out  1  one-cycle pulse; loader write performed this cycle.
REQ-010 hit_req  in  1  collision damage request; held until hit_ack.
REQ-011 hit_addr  in  ADDR_W  address of the brick struck.
REQ-012 hit_ack  out  1  one-cycle pulse; damage request completed.
REQ-013 hit_valid  out  1  qualifies hit_ack; 1 = a brick was present and damaged.
REQ-014 hit_destroyed  out  1  qualifies hit_ack; 1 = damaged brick reached health 0.
REQ-015 ram_addr  out  ADDR_W  brick RAM address.
REQ-016 ram_wdata  out  HP_W  brick RAM write data.
REQ-017 ram_we  out  1  brick RAM write enable.
REQ-018 ram_rdata  in  HP_W  brick RAM read data, valid one cycle after ram_addr is presented.
REQ-019 lvl_load  in  1  one-cycle pulse; latch lvl_total as remaining level health.
REQ-020 lvl_total  in  TOT_W  total health of the level being loaded.
REQ-021 hp_left  out  TOT_W  remaining level health.
REQ-022 level_clear  out  1  level loaded and hp_left == 0.
REQ-023 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-024 FSM states: IDLE, LD_WR, HIT_RD, HIT_CHK, HIT_WR; one-hot or binary encoding is free.
REQ-025 IDLE: ld_req=1 -> latch ld_addr/ld_health, go LD_WR; else hit_req=1 -> latch hit_addr, go HIT_RD; else stay; loader has fixed priority.
REQ-026 LD_WR: ram_addr=latched addr, ram_wdata=latched health, ram_we=1, ld_grant=1; next IDLE (max loader rate one write per 2 cycles).
REQ-027 HIT_RD: ram_addr=latched hit addr, ram_we=0; next HIT_CHK.
REQ-028 HIT_CHK: ram_rdata==0 -> hit_ack=1, hit_valid=0, hit_destroyed=0, no write, next IDLE; else latch rdata, next HIT_WR.
REQ-029 HIT_WR: ram_we=1, ram_wdata=latched rdata-1, hit_ack=1, hit_valid=1, hit_destroyed=(latched rdata==1), hp_left decrements by 1; next IDLE.
REQ-030 Latency hit_req seen in IDLE (cycle 0) to hit_ack: cycle 3 for a present brick, cycle 2 for an empty slot.
REQ-031 Requests are sampled only in IDLE; a requester deasserting before its grant/ack is a protocol violation, behaviour undefined.
REQ-032 Outside LD_WR/HIT_WR ram_we=0; in IDLE ram_addr=0, ram_wdata=0.
REQ-033 hp_left saturates at 0; a decrement at 0 leaves 0.
REQ-034 lvl_load and decrement in the same cycle: lvl_load wins, hp_left=lvl_total.
REQ-035 A loaded flag sets on lvl_load and clears on reset; level_clear = loaded & (hp_left==0).
REQ-036 lvl_load with lvl_total=0 asserts level_clear the following cycle.

Reset
REQ-037 resetn=0 at any posedge, including mid-transaction: state=IDLE, all latches cleared, hp_left=0, loaded=0.
REQ-038 During and after reset until next request: ld_grant, hit_ack, hit_valid, hit_destroyed, ram_we, busy, level_clear all 0; ram_addr=0, ram_wdata=0.
REQ-039 An interrupted transaction is dropped, never acknowledged; requester must re-request.

Structure
REQ-040 ADDR_W, HP_W, TOT_W defaults come from the shared macros file alongside BRICKNUM; FSM state encodings stay local.
REQ-041 hp_left, loaded flag and level_clear live in sub-module brick_hp_tracker (inputs load, total, dec; outputs hp_left, level_clear).

Verification
REQ-042 ld_req=1, ld_addr=17, ld_health=3 -> next cycle ram_we=1, ram_addr=17, ram_wdata=3, ld_grant=1; busy deasserts the cycle after.
REQ-043 RAM[49]=2, hit_req addr 49 -> ack cycle 3, hit_valid=1, hit_destroyed=0, RAM[49]=1, hp_left drops by 1.
REQ-044 RAM[5]=0, hit_req addr 5 -> ack cycle 2, hit_valid=0, no ram_we, hp_left unchanged.
REQ-045 ld_req and hit_req asserted together -> loader granted first, hit acked afterward; both RAM writes correct.
REQ-046 lvl_load, lvl_total=1; hit on brick with health 1 -> hit_destroyed=1, hp_left=0, level_clear=1; further hit leaves hp_left at 0.
REQ-047 resetn=0 during HIT_CHK -> no hit_ack, ram_we=0, state IDLE, hp_left=0, level_clear=0.
